// File: rtl/change_dispenser_pkg.sv
// Shared constants for the change dispenser: coin indices, nickel values, FSM states.
package change_dispenser_pkg;

    localparam int NUM_COINS    = 4;
    localparam int COIN_NICKEL  = 0;
    localparam int COIN_DIME    = 1;
    localparam int COIN_QUARTER = 2;
    localparam int COIN_DOLLAR  = 3;

    localparam int VAL_NICKEL   = 1;
    localparam int VAL_DIME     = 2;
    localparam int VAL_QUARTER  = 5;
    localparam int VAL_DOLLAR   = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_GAP,
        ST_DONE
    } state_e;

    function automatic int coin_value(input logic [1:0] idx);
        case (idx)
            2'(COIN_NICKEL):  coin_value = VAL_NICKEL;
            2'(COIN_DIME):    coin_value = VAL_DIME;
            2'(COIN_QUARTER): coin_value = VAL_QUARTER;
            default:          coin_value = VAL_DOLLAR;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Payout request/status bundle between the credit datapath and the dispenser.
// With CHANGE_TALLY_EN defined the bundle also carries the per-coin tally.
interface change_dispenser_if #(
    parameter int AMT_W = 8
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic [3:0]       tube_empty;
    logic [3:0]       coin_eject;
    logic             busy;
    logic             done;
    logic             short_flag;
    logic [AMT_W-1:0] remaining;

`ifdef CHANGE_TALLY_EN
    logic [31:0]      tally;

    modport master (
        output start, amount, tube_empty,
        input  coin_eject, busy, done, short_flag, remaining, tally
    );
    modport slave (
        input  start, amount, tube_empty,
        output coin_eject, busy, done, short_flag, remaining, tally
    );
`else
    modport master (
        output start, amount, tube_empty,
        input  coin_eject, busy, done, short_flag, remaining
    );
    modport slave (
        input  start, amount, tube_empty,
        output coin_eject, busy, done, short_flag, remaining
    );
`endif

endinterface

// File: rtl/change_dispenser_coin_picker.sv
// Greedy selector: largest available coin whose value fits in the amount still owed.
module change_dispenser_coin_picker
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] i_remaining,
    input  logic [3:0]       i_tube_empty,
    output logic             o_found,
    output logic [1:0]       o_sel,
    output logic [AMT_W-1:0] o_value
);

    // Ascending scan so the highest qualifying denomination wins.
    always_comb begin
        o_found = 1'b0;
        o_sel   = 2'd0;
        o_value = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (!i_tube_empty[i] && (AMT_W'(coin_value(2'(i))) <= i_remaining)) begin
                o_found = 1'b1;
                o_sel   = 2'(i);
                o_value = AMT_W'(coin_value(2'(i)));
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin payout sequencer: greedy coin selection, fixed pulse/gap solenoid timing.
// Optional CHANGE_TALLY_EN adds saturating per-denomination eject counters.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int AMT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    change_dispenser_if.slave   bus
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_e           r_state;
    logic [TW-1:0]    r_timer;
    logic [3:0]       r_coin_eject;
    logic             r_busy;
    logic             r_done;
    logic             r_short;
    logic [AMT_W-1:0] r_remaining;

    logic             w_found;
    logic [1:0]       w_sel;
    logic [AMT_W-1:0] w_value;

    change_dispenser_coin_picker #(.AMT_W(AMT_W)) u_picker (
        .i_remaining  (r_remaining),
        .i_tube_empty (bus.tube_empty),
        .o_found      (w_found),
        .o_sel        (w_sel),
        .o_value      (w_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_coin_eject <= 4'b0000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_short      <= 1'b0;
            r_remaining  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_remaining <= bus.amount;
                        r_short     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (r_remaining == '0) begin
                        r_state <= ST_DONE;
                    end else if (!w_found) begin
                        r_short <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        // Picker guarantees w_value <= r_remaining, so no underflow.
                        r_coin_eject <= 4'b0001 << w_sel;
                        r_remaining  <= r_remaining - w_value;
                        r_timer      <= TW'(PULSE_CYCLES - 1);
                        r_state      <= ST_EJECT;
                    end
                end
                ST_EJECT: begin
                    if (r_timer == '0) begin
                        r_coin_eject <= 4'b0000;
                        r_timer      <= TW'(GAP_CYCLES - 1);
                        r_state      <= ST_GAP;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_timer == '0) begin
                        r_state <= ST_SELECT;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.coin_eject = r_coin_eject;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.short_flag = r_short;
    assign bus.remaining  = r_remaining;

`ifdef CHANGE_TALLY_EN
    logic w_pick;
    assign w_pick = (r_state == ST_SELECT) && (r_remaining != '0) && w_found;

    for (genvar g = 0; g < NUM_COINS; g++) begin : g_tally
        logic [7:0] r_cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= 8'd0;
            end else if (w_pick && (w_sel == 2'(g)) && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
        assign bus.tally[g*8 +: 8] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_CYCLES=2, GAP_CYCLES=1.
module tb_change_dispenser;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    change_dispenser_if #(.AMT_W(8)) bus();

    change_dispenser #(
        .PULSE_CYCLES (2),
        .GAP_CYCLES   (1),
        .AMT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse recorder: coin, pulse length, and zero-run between pulses of one payout.
    logic [3:0] q_coin[$];
    int         q_len[$];
    int         q_gap[$];
    logic [3:0] m_cur = 4'b0000;
    int         m_len = 0;
    int         m_zero = 0;
    bit         m_prev = 1'b0;

    always begin
        @(posedge clk);
        #1;
        checks++;
        assert ($onehot0(bus.coin_eject)) else begin
            errors++;
            $error("FAIL onehot got %b want at most one bit", bus.coin_eject);
        end
        if (bus.coin_eject != 4'b0000) begin
            if (m_cur == 4'b0000) begin
                if (m_prev) q_gap.push_back(m_zero);
                m_cur = bus.coin_eject;
                m_len = 1;
            end else if (bus.coin_eject == m_cur) begin
                m_len++;
            end else begin
                q_coin.push_back(m_cur);
                q_len.push_back(m_len);
                m_cur = bus.coin_eject;
                m_len = 1;
            end
        end else begin
            if (m_cur != 4'b0000) begin
                q_coin.push_back(m_cur);
                q_len.push_back(m_len);
                m_cur  = 4'b0000;
                m_prev = 1'b1;
                m_zero = 0;
            end
            m_zero++;
        end
        if (!bus.busy) m_prev = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic clear_rec();
        q_coin.delete();
        q_len.delete();
        q_gap.delete();
    endtask

    task automatic start_pay(input logic [7:0] amt, input logic [3:0] te);
        clear_rec();
        bus.start      = 1'b1;
        bus.amount     = amt;
        bus.tube_empty = te;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        assert (bus.done === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout got done=%b want 1 within 200 cycles", tag, bus.done);
        end
    endtask

    task automatic check_seq(input string tag, input logic [3:0] exp[$]);
        checks++;
        assert (q_coin.size() === exp.size()) else begin
            errors++;
            $error("FAIL %s_count got %0d want %0d", tag, q_coin.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < q_coin.size(); i++) begin
            checks++;
            assert (q_coin[i] === exp[i]) else begin
                errors++;
                $error("FAIL %s_coin%0d got %b want %b", tag, i, q_coin[i], exp[i]);
            end
            checks++;
            assert (q_len[i] === 2) else begin
                errors++;
                $error("FAIL %s_len%0d got %0d want 2", tag, i, q_len[i]);
            end
        end
        for (int i = 0; i < q_gap.size(); i++) begin
            checks++;
            assert (q_gap[i] === 2) else begin
                errors++;
                $error("FAIL %s_gap%0d got %0d want 2", tag, i, q_gap[i]);
            end
        end
    endtask

    initial begin
        logic [3:0] e27[$];
        logic [3:0] eq[$];
        logic [3:0] eqn[$];
        logic [3:0] e0[$];
        bit         saw_done;
        int         cyc;

        e27 = '{4'b1000, 4'b0100, 4'b0010};
        eq  = '{4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        eqn = '{4'b1000, 4'b0010, 4'b0010, 4'b0010};

        bus.start      = 1'b0;
        bus.amount     = 8'd0;
        bus.tube_empty = 4'b0000;
        reset          = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_eject", 32'(bus.coin_eject), 32'h0);
        chk("rst_busy",  32'(bus.busy),       32'h0);
        chk("rst_done",  32'(bus.done),       32'h0);
        chk("rst_short", 32'(bus.short_flag), 32'h0);
        chk("rst_rem",   32'(bus.remaining),  32'h0);
        reset = 1'b0;
        tick();

        // 27 = dollar + quarter + dime, twice for the tally
        start_pay(8'd27, 4'b0000);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        wait_done("t1");
        chk("t1_rem",   32'(bus.remaining),  32'h0);
        chk("t1_short", 32'(bus.short_flag), 32'h0);
        chk("t1_busy_end", 32'(bus.busy),    32'h0);
        check_seq("t1", e27);
        tick();
        chk("t1_done_pulse", 32'(bus.done), 32'h0);

        start_pay(8'd27, 4'b0000);
        wait_done("t1b");
        check_seq("t1b", e27);
`ifdef CHANGE_TALLY_EN
        chk("tally", bus.tally, 32'h02020200);
`endif
        tick();

        // quarter tube empty
        start_pay(8'd27, 4'b0100);
        wait_done("t2");
        chk("t2_rem",   32'(bus.remaining),  32'h0);
        chk("t2_short", 32'(bus.short_flag), 32'h0);
        check_seq("t2", eq);
        tick();

        // quarter and nickel empty: one nickel short
        start_pay(8'd27, 4'b0101);
        wait_done("t3");
        chk("t3_rem",   32'(bus.remaining),  32'h1);
        chk("t3_short", 32'(bus.short_flag), 32'h1);
        check_seq("t3", eqn);
        tick();
        tick();
        tick();
        chk("t3_short_hold", 32'(bus.short_flag), 32'h1);
        chk("t3_rem_hold",   32'(bus.remaining),  32'h1);

        // amount 0: done two cycles after accept, short cleared by accept
        start_pay(8'd0, 4'b0000);
        chk("t4_busy0",  32'(bus.busy),       32'h1);
        chk("t4_done0",  32'(bus.done),       32'h0);
        chk("t4_short",  32'(bus.short_flag), 32'h0);
        tick();
        chk("t4_busy1",  32'(bus.busy), 32'h1);
        chk("t4_done1",  32'(bus.done), 32'h0);
        tick();
        chk("t4_done2",  32'(bus.done), 32'h1);
        chk("t4_busy2",  32'(bus.busy), 32'h0);
        tick();
        chk("t4_done3",  32'(bus.done), 32'h0);
        check_seq("t4", e0);

        // start while busy is ignored
        start_pay(8'd27, 4'b0000);
        tick();
        tick();
        tick();
        bus.start  = 1'b1;
        bus.amount = 8'd5;
        tick();
        tick();
        bus.start = 1'b0;
        wait_done("t5");
        chk("t5_rem", 32'(bus.remaining), 32'h0);
        check_seq("t5", e27);
        tick();
        tick();
        chk("t5_idle_busy", 32'(bus.busy), 32'h0);

        // async reset in the middle of a pulse
        start_pay(8'd27, 4'b0000);
        cyc = 0;
        while (bus.coin_eject == 4'b0000 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("t6_in_eject", 32'(bus.coin_eject != 4'b0000), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_eject_async", 32'(bus.coin_eject), 32'h0);
        chk("t6_busy_async",  32'(bus.busy),       32'h0);
        chk("t6_rem_async",   32'(bus.remaining),  32'h0);
        tick();
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.coin_eject !== 4'b0000) saw_done = 1'b1;
        end
        chk("t6_no_done", 32'(saw_done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Sequencer that pays out customer change after a vend or cancel. It accepts an amount in nickel units from vending_machine and breaks it into coins greedily. It then drives the coin-eject solenoids one coin at a time with fixed pulse and gap timing, and skips any coin tube reported empty. It sits between the vending_machine credit datapath and the physical coin-return mechanism.

Parameters:
PULSE_CYCLES, 4, clk cycles each solenoid pulse is held high (≥1)
GAP_CYCLES, 2, clk cycles of idle between successive coin pulses (≥1)
AMT_W, 8, width of the amount in nickel units (max 255 = $12.75)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request payout of amount; sampled only in IDLE
amount  input  AMT_W  change owed, in nickels
tube_empty  input  4  empty flags {dollar, quarter, dime, nickel}; 1 = denomination unavailable
coin_eject  output  4  one-hot solenoid drive {dollar, quarter, dime, nickel}
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when payout ends
short_flag  output  1  payout ended with money still owed; held until next accepted start
remaining  output  AMT_W  nickels still owed; after done it holds the shortfall

Behaviour:
- Reset (async): state IDLE; coin_eject=0, busy=0, done=0, short_flag=0, remaining=0, all timers 0. Asserting reset mid-pulse drops coin_eject immediately.
- Denomination values in nickels: dollar 20, quarter 5, dime 2, nickel 1.
- IDLE:
  - start=1 latches amount into remaining, clears short_flag, sets busy, and moves to SELECT on the next edge.
  - start in any other state is ignored.
- SELECT (1 cycle): picks the largest denomination d with value(d) ≤ remaining and tube_empty[d]=0.
  - If remaining=0 → DONE.
  - If no such d exists → DONE and set short_flag.
  - Otherwise → EJECT with sel=d, and remaining -= value(d) on the same edge.
- EJECT: coin_eject=onehot(sel) for exactly PULSE_CYCLES cycles, then → GAP.
  - tube_empty is not re-sampled during the pulse.
- GAP: coin_eject=0 for GAP_CYCLES cycles, then → SELECT.
  - tube_empty is sampled fresh at every SELECT.
- DONE (1 cycle): done=1 and busy drops to 0 on the same edge, then → IDLE.
- Latency with amount=0: start accepted at edge N, busy=1 after N, SELECT at N+1, done=1 after N+2.
- Per-coin period: 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- coin_eject is never multi-hot. It is registered, with no combinational path from the inputs.
- Arithmetic: subtraction is AMT_W bits and cannot underflow, because selection guarantees value ≤ remaining.

Optional Feature:
CHANGE_TALLY_EN
- Defined: adds output tally, 4×8 bits packed as {dollar, quarter, dime, nickel}, counting coins ejected since reset.
  - Each counter increments on entry to EJECT and saturates at 255.
  - Reset clears all counters.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header vm_defs.vh (include-guarded), used by vending_machine and num_to_coins:
  - coin index localparams COIN_NICKEL=0, COIN_DIME=1, COIN_QUARTER=2, COIN_DOLLAR=3;
  - nickel-unit values VAL_NICKEL=1, VAL_DIME=2, VAL_QUARTER=5, VAL_DOLLAR=20;
  - FSM state encodings.
- One natural sub-module, coin_picker: combinational priority selector (remaining, tube_empty) → {found, sel, value}. It is instantiated by the FSM in SELECT.

Test Plan:
- PULSE=2, GAP=1, amount=27, no tubes empty → coin_eject pulses dollar, quarter, dime, each 2 cycles with a 1-cycle gap; done with remaining=0 and short_flag=0.
- amount=27, tube_empty=4'b0100 (quarter empty) → dollar, dime, dime, dime, nickel; remaining=0.
- amount=27, tube_empty=4'b0101 (quarter and nickel empty) → dollar, dime×3; done with short_flag=1 and remaining=1.
- amount=0 → no coin_eject; done exactly 2 cycles after the accepting edge; busy high for 2 cycles.
- start pulsed again while busy with amount=5 → ignored, and the original payout completes unchanged; then reset asserted mid-EJECT → coin_eject, busy and remaining go to 0 asynchronously, and no done pulse follows.
- With CHANGE_TALLY_EN: two payouts of 27 → dollar=2, quarter=2, dime=2, nickel=0 in the tally.
